l2_conv_post_accumulator: RTL

Consumer end of the layer-2 convolution datapath. Takes the registered 22-bit signed partial-sum stream and its valid bit from the L2 adder tree. Accumulates `ChanGroups` consecutive partials per output pixel on top of a signed bias, then applies ReLU and a round-shift-saturate to an 8-bit unsigned activation. Counts pixels per feature map and flags the last pixel, so the layer controller can sequence maps.

---
 rtl/l2_conv_post_accumulator_if.sv | 25 ++
 rtl/l2_conv_post_accumulator.sv | 92 +++++++++
 2 files changed

// File: rtl/l2_conv_post_accumulator_if.sv
// l2_conv_post_accumulator_if: partial-sum input and activation output bundle of the L2 post-accumulator
interface l2_conv_post_accumulator_if #(
    parameter int InWidth   = 22,
    parameter int BiasWidth = 16,
    parameter int OutWidth  = 8
);
    logic                 start_i;
    logic [BiasWidth-1:0] bias_i;
    logic                 vbit_i;
    logic [InWidth-1:0]   data_i;
    logic [OutWidth-1:0]  data_o;
    logic                 vbit_o;
    logic                 done_o;
    logic                 busy_o;

    modport master (
        output start_i, bias_i, vbit_i, data_i,
        input  data_o, vbit_o, done_o, busy_o
    );

    modport slave (
        input  start_i, bias_i, vbit_i, data_i,
        output data_o, vbit_o, done_o, busy_o
    );
endinterface

// File: rtl/l2_conv_post_accumulator.sv
// l2_conv_post_accumulator: bias + channel-group accumulation, ReLU and round-shift-saturate per output pixel
module l2_conv_post_accumulator #(
    parameter int InWidth      = 22,
    parameter int AccWidth     = 30,
    parameter int BiasWidth    = 16,
    parameter int OutWidth     = 8,
    parameter int ChanGroups   = 4,
    parameter int PixelsPerMap = 196,
    parameter int Shift        = 8
) (
    input logic                   clk,
    input logic                   rstn,
    l2_conv_post_accumulator_if.slave bus
);
    localparam int GrpW = ChanGroups > 1 ? $clog2(ChanGroups) : 1;
    localparam int PixW = PixelsPerMap > 1 ? $clog2(PixelsPerMap) : 1;
    localparam logic [GrpW-1:0] GrpLast = GrpW'(ChanGroups - 1);
    localparam logic [PixW-1:0] PixLast = PixW'(PixelsPerMap - 1);
    localparam logic [AccWidth:0] Half = (AccWidth + 1)'(1) << (Shift - 1);
    localparam logic [AccWidth:0] MaxOut = (AccWidth + 1)'((1 << OutWidth) - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state, state_nx;
    logic signed [AccWidth-1:0] acc, acc_base, sum, data_ext, bias_ext;
    logic [BiasWidth-1:0]       bias_q;
    logic [GrpW-1:0]            grp_cnt, grp_nx;
    logic [PixW-1:0]            pix_cnt;
    logic                       accept, pix_end, map_end, arm;
    logic [AccWidth:0]          rnd, shifted;
    logic [OutWidth-1:0]        act, data_q;
    logic                       vbit_q, done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        arm      = state == IDLE && bus.start_i;
        accept   = state == RUN && bus.vbit_i;
        pix_end  = accept && grp_cnt == GrpLast;
        map_end  = pix_end && pix_cnt == PixLast;
        state_nx = state == IDLE ? (bus.start_i ? RUN : IDLE) : (map_end ? IDLE : RUN);
    end

    // The first partial of every pixel starts from the bias instead of the previous sum.
    always_comb begin
        data_ext = {{(AccWidth-InWidth){bus.data_i[InWidth-1]}}, bus.data_i};
        bias_ext = {{(AccWidth-BiasWidth){bias_q[BiasWidth-1]}}, bias_q};
        acc_base = grp_cnt == '0 ? bias_ext : acc;
        sum      = acc_base + data_ext;
        grp_nx   = grp_cnt == GrpLast ? '0 : grp_cnt + 1'b1;
        rnd      = {sum[AccWidth-1], sum} + Half;
        shifted  = rnd >> Shift;
        act      = (sum[AccWidth-1] || sum == '0) ? '0 :
                   shifted > MaxOut ? '1 : shifted[OutWidth-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            bias_q  <= '0;
            grp_cnt <= '0;
            pix_cnt <= '0;
            data_q  <= '0;
            vbit_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            vbit_q <= pix_end;
            done_q <= map_end;
            if (arm) begin
                bias_q  <= bus.bias_i;
                grp_cnt <= '0;
                pix_cnt <= '0;
            end
            if (accept) begin
                acc     <= sum;
                grp_cnt <= grp_nx;
            end
            if (pix_end) begin
                data_q  <= act;
                pix_cnt <= map_end ? '0 : pix_cnt + 1'b1;
            end
        end
    end

    assign bus.data_o = data_q;
    assign bus.vbit_o = vbit_q;
    assign bus.done_o = done_q;
    assign bus.busy_o = state == RUN;
endmodule
